// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the two-port asynchronous SRAM arbiter.
package ram_arbiter_pkg;

  // Transaction sequencer states: strobes are set up, held for the access
  // window, then released with a one-clock hold before returning to idle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Width of the ACCESS down-counter; never narrower than one bit.
  function automatic int wait_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin arbiter with a one-cycle mask for a port just acked.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic       r_last;   // 1 when port 1 was the most recent winner
  logic [1:0] w_masked;
  logic [1:0] w_pool;

  // Grant selection: a just-acked port steps aside for a contending port;
  // when it is the only requester it is served again so one port can stream.
  always_comb begin
    w_masked = i_req & ~i_mask;
    w_pool   = (w_masked != 2'b00) ? w_masked : i_req;
    o_grant  = w_pool;
    if (w_pool == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  // Remember the last winner; reset leaves port 0 favoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_advance && (o_grant != 2'b00)) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one asynchronous SRAM between a CPU port (0) and a video/DMA port (1).
// All SRAM strobes and requester outputs come straight from flops.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_data_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  localparam int                WAIT_W   = wait_w(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  state_t              r_state, w_state_n;
  logic [WAIT_W-1:0]   r_cnt, w_cnt_n;
  logic                r_sel, w_sel_n;
  logic                r_lat_we, w_lat_we_n;
  logic [1:0]          r_ack_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;
  logic [DATA_W-1:0]   r_rdata, w_rdata_n;
  logic                r_cs_n, w_cs_n_n;
  logic                r_we_n, w_we_n_n;
  logic                r_oe_n, w_oe_n_n;
  logic                r_data_oe, w_data_oe_n;
  logic                r_ack0, w_ack0_n;
  logic                r_ack1, w_ack1_n;
  logic                r_busy, w_busy_n;
  logic [1:0]          w_grant;
  logic                w_accept;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     ({req1, req0}),
    .i_mask    (r_ack_d),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);

  // Next state and next registered outputs for the transaction sequencer.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_sel_n     = r_sel;
    w_lat_we_n  = r_lat_we;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_rdata_n   = r_rdata;
    w_cs_n_n    = r_cs_n;
    w_we_n_n    = 1'b1;
    w_oe_n_n    = 1'b1;
    w_data_oe_n = r_data_oe;
    w_ack0_n    = 1'b0;
    w_ack1_n    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cs_n_n    = 1'b1;
        w_data_oe_n = 1'b0;
        if (w_accept) begin
          w_state_n   = SETUP;
          w_sel_n     = w_grant[1];
          w_lat_we_n  = w_grant[1] ? we1    : we0;
          w_addr_n    = w_grant[1] ? addr1  : addr0;
          w_wdata_n   = w_grant[1] ? wdata1 : wdata0;
          w_cs_n_n    = 1'b0;
          w_data_oe_n = w_grant[1] ? we1    : we0;
        end
      end
      SETUP: begin
        w_state_n = ACCESS;
        w_cnt_n   = CNT_LOAD;
        w_cs_n_n  = 1'b0;
        w_we_n_n  = ~r_lat_we;
        w_oe_n_n  = r_lat_we;
      end
      ACCESS: begin
        w_cs_n_n = 1'b0;
        if (r_cnt == '0) begin
          // Last access clock: sample the bus while OE is still asserted.
          w_state_n = HOLD;
          if (!r_lat_we) begin
            w_rdata_n = ram_rdata;
          end
          w_ack0_n = ~r_sel;
          w_ack1_n = r_sel;
        end else begin
          w_cnt_n  = r_cnt - 1'b1;
          w_we_n_n = ~r_lat_we;
          w_oe_n_n = r_lat_we;
        end
      end
      HOLD: begin
        w_state_n   = IDLE;
        w_cs_n_n    = 1'b1;
        w_data_oe_n = 1'b0;
      end
      default: begin
        w_state_n   = IDLE;
        w_cs_n_n    = 1'b1;
        w_data_oe_n = 1'b0;
      end
    endcase
    w_busy_n = (w_state_n != IDLE);
  end

  // State, latched request fields and every output flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_lat_we  <= 1'b0;
      r_ack_d   <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cs_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_data_oe <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_sel     <= w_sel_n;
      r_lat_we  <= w_lat_we_n;
      r_ack_d   <= {r_ack1, r_ack0};
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_rdata   <= w_rdata_n;
      r_cs_n    <= w_cs_n_n;
      r_we_n    <= w_we_n_n;
      r_oe_n    <= w_oe_n_n;
      r_data_oe <= w_data_oe_n;
      r_ack0    <= w_ack0_n;
      r_ack1    <= w_ack1_n;
      r_busy    <= w_busy_n;
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign ram_data_oe = r_data_oe;
  assign ram_cs_n    = r_cs_n;
  assign ram_we_n    = r_we_n;
  assign ram_oe_n    = r_oe_n;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter paired with a behavioural SRAM and a strobe monitor.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, ram_data_oe, ram_cs_n, ram_we_n, ram_oe_n;
  logic [7:0]  rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mon_err = 0;

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_data_oe(ram_data_oe),
    .ram_rdata(ram_rdata), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model: write when selected, write-enabled and bus driven.
  logic [7:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (!ram_cs_n && !ram_we_n && ram_data_oe) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = (!ram_cs_n && !ram_oe_n) ? mem[ram_addr] : 8'h00;

  // Strobe monitor on the falling edge.
  logic        prev_cs_low = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_wdata = 8'h0;
  always @(negedge clk) begin
    if (!ram_we_n && !ram_oe_n) mon_err++;
    if ((!ram_we_n || !ram_oe_n) && ram_cs_n) mon_err++;
    if (ram_data_oe && !ram_oe_n) mon_err++;
    if (prev_cs_low && !ram_cs_n && (ram_addr != prev_addr || ram_wdata != prev_wdata)) mon_err++;
    prev_cs_low = !ram_cs_n;
    prev_addr   = ram_addr;
    prev_wdata  = ram_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait (bounded) for either ack, counting rising edges.
  task automatic wait_ack(output int lat, output logic [1:0] ackv);
    lat = -1;
    ackv = 2'b00;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 || ack1) begin
        lat = n;
        ackv = {ack1, ack0};
        break;
      end
    end
  endtask

  task automatic do_txn(input int port, input logic we, input logic [15:0] a,
                        input logic [7:0] d, output int lat, output logic [1:0] ackv,
                        output logic [7:0] rd);
    @(negedge clk);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    wait_ack(lat, ackv);
    rd = rdata;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  typedef struct {
    int         port;
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t        tbl [7];
  logic [1:0]  order [4];
  int          tstamp [4];
  int          lat, k, n, ack_seen;
  logic [1:0]  ackv;
  logic [7:0]  rd, last_rd;
  logic [15:0] b2b_addr [4];
  logic [7:0]  b2b_data [4];

  initial begin
    tbl[0] = '{0, 1'b1, 16'h1234, 8'hA5, 8'h00};
    tbl[1] = '{0, 1'b0, 16'h1234, 8'h00, 8'hA5};
    tbl[2] = '{0, 1'b1, 16'h0000, 8'h5A, 8'h00};
    tbl[3] = '{1, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
    tbl[4] = '{0, 1'b0, 16'h0000, 8'h00, 8'h5A};
    tbl[5] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
    tbl[6] = '{1, 1'b0, 16'h1234, 8'h00, 8'hA5};
    b2b_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    b2b_data = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({ram_cs_n, ram_we_n, ram_oe_n, ack0, ack1, busy, ram_data_oe}), 32'h70);
    check("reset_data", 32'({rdata, ram_addr, ram_wdata}), 32'h0);
    reset = 1'b0;

    // Both ports requesting reads and held: grants must alternate.
    for (int i = 0; i < 4; i++) begin order[i] = 2'b00; tstamp[i] = 0; end
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    k = 0;
    n = 0;
    while (k < 4 && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack0 || ack1) begin
        order[k] = {ack1, ack0};
        tstamp[k] = n;
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_count", 32'(k), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), (i % 2 == 1) ? 32'h2 : 32'h1);
    check("rr_first_lat", 32'(tstamp[0]), 32'd5);
    for (int i = 1; i < 4; i++) check("rr_gap", 32'(tstamp[i] - tstamp[i-1]), 32'd6);
    check("rr_rdata", 32'(rdata), 32'h0);

    // Table of single transactions.
    last_rd = 8'h00;
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, ackv, rd);
      check("tbl_lat", 32'(lat), 32'd5);
      check("tbl_ackport", 32'(ackv), (tbl[i].port == 1) ? 32'h2 : 32'h1);
      if (!tbl[i].we) last_rd = tbl[i].exp_rd;
      check("tbl_rdata", 32'(rd), 32'(last_rd));
    end
    check("mem_ffff", 32'(mem[16'hFFFF]), 32'h3C);
    check("mem_0000", 32'(mem[16'h0000]), 32'h5A);

    // Back-to-back writes on port 1 with req held throughout.
    for (int i = 0; i < 4; i++) begin order[i] = 2'b00; tstamp[i] = 0; end
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = b2b_addr[0]; wdata1 = b2b_data[0];
    k = 0;
    n = 0;
    while (k < 4 && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack0 || ack1) begin
        order[k] = {ack1, ack0};
        tstamp[k] = n;
        k++;
        if (k < 4) begin addr1 = b2b_addr[k]; wdata1 = b2b_data[k]; end
      end
    end
    req1 = 1'b0;
    check("b2b_count", 32'(k), 32'd4);
    check("b2b_first_lat", 32'(tstamp[0]), 32'd5);
    for (int i = 1; i < 4; i++) check("b2b_gap", 32'(tstamp[i] - tstamp[i-1]), 32'd6);
    for (int i = 0; i < 4; i++) check("b2b_port", 32'(order[i]), 32'h2);
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, b2b_addr[i], 8'h00, lat, ackv, rd);
      check("b2b_readback", 32'(rd), 32'(b2b_data[i]));
    end

    // Reset while a write is in its access phase.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 8'h77;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midwr_we_low", 32'({ram_cs_n, ram_we_n}), 32'h0);
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midwr_strobes", 32'({ram_cs_n, ram_we_n, ram_oe_n, ram_data_oe}), 32'hE);
    check("midwr_ack_busy", 32'({ack0, ack1, busy}), 32'h0);
    reset = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 || ack1 || busy) ack_seen++;
    end
    check("midwr_quiet", 32'(ack_seen), 32'd0);

    check("strobe_monitor", 32'(mon_err), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
